demux_1_2_stream: RTL and testbench

//  1-to-2 stream demultiplexer: the receive-side counterpart of the 2:1 mux.

---
 rtl/demux_1_2_stream_pkg.sv | 9 +
 rtl/demux_1_2_stream_slice.sv | 37 +++
 rtl/demux_1_2_stream.sv | 61 ++++++
 tb/tb_demux_1_2_stream.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/demux_1_2_stream_pkg.sv
// demux_1_2_stream_pkg: shared constants for the 1:2 stream demux
//   WIDTH_DEF            default payload width
//   ST_IDLE/LOCK0/LOCK1  route FSM encodings
package demux_1_2_stream_pkg;
    localparam int WIDTH_DEF = 8;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;
endpackage

// File: rtl/demux_1_2_stream_slice.sv
// stream_reg_slice: one-entry registered output stage
//   clk, rst        clock, async active-high reset
//   d_data/d_last   beat to capture when d_load
//   d_load          capture strobe (only asserted while can_load)
//   q_data/q_last   registered beat, stable while q_valid & !q_ready
//   q_valid/q_ready downstream handshake
//   can_load        slot is empty or draining this cycle
module stream_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_data,
    input  logic             d_last,
    input  logic             d_load,
    output logic [WIDTH-1:0] q_data,
    output logic             q_last,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             can_load
);
    assign can_load = !q_valid | q_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_data  <= '0;
            q_last  <= 1'b0;
            q_valid <= 1'b0;
        end else if (d_load) begin
            q_data  <= d_data;
            q_last  <= d_last;
            q_valid <= 1'b1;
        end else if (q_ready) begin
            q_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux_1_2_stream.sv
// demux_1_2_stream: routes whole packets from one stream to one of two registered outputs
//   clk, rst                          clock, async active-high reset
//   in_data/in_sel/in_last/in_valid   input beat; in_sel used on first beat only
//   in_ready                          ready of the currently routed output slice
//   outN_data/outN_last/outN_valid    registered channel N beat
//   outN_ready                        channel N consumer accepts
module demux_1_2_stream
    import demux_1_2_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             out1_valid,
    input  logic             out1_ready
);
    logic [1:0] state, nxt;
    logic       route, acc, can0, can1;

    // The lock overrides in_sel for every beat after the first of a packet.
    assign route    = (state == ST_LOCK0) ? 1'b0 : (state == ST_LOCK1) ? 1'b1 : in_sel;
    assign in_ready = route ? can1 : can0;
    assign acc      = in_valid & in_ready;

    always_comb begin
        nxt = !acc ? state :
              in_last ? ST_IDLE :
              (state == ST_LOCK0 || state == ST_LOCK1) ? state :
              route ? ST_LOCK1 : ST_LOCK0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    stream_reg_slice #(.WIDTH(WIDTH)) u_s0 (
        .clk(clk), .rst(rst),
        .d_data(in_data), .d_last(in_last), .d_load(acc & !route),
        .q_data(out0_data), .q_last(out0_last), .q_valid(out0_valid),
        .q_ready(out0_ready), .can_load(can0)
    );

    stream_reg_slice #(.WIDTH(WIDTH)) u_s1 (
        .clk(clk), .rst(rst),
        .d_data(in_data), .d_last(in_last), .d_load(acc & route),
        .q_data(out1_data), .q_last(out1_last), .q_valid(out1_valid),
        .q_ready(out1_ready), .can_load(can1)
    );
endmodule

// File: tb/tb_demux_1_2_stream.sv
// tb_demux_1_2_stream: scoreboard bench for demux_1_2_stream
module tb_demux_1_2_stream;
    logic       clk = 0, rst = 1;
    logic [7:0] in_data = 0;
    logic       in_sel = 0, in_last = 0, in_valid = 0, in_ready;
    logic [7:0] out0_data, out1_data;
    logic       out0_last, out0_valid, out1_last, out1_valid;
    logic       out0_ready, out1_ready;
    logic       dir0 = 1, dir1 = 1, rr0 = 1, rr1 = 1, rand_rdy = 0;
    int         checks = 0, errors = 0;
    logic [8:0] q0[$], q1[$];
    logic [1:0] mst = 0;

    assign out0_ready = rand_rdy ? rr0 : dir0;
    assign out1_ready = rand_rdy ? rr1 : dir1;

    demux_1_2_stream dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_last(out0_last),
        .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_last(out1_last),
        .out1_valid(out1_valid), .out1_ready(out1_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: route lock FSM plus one expected-beat queue per channel.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            mst = 0;
        end else begin
            logic r, er;
            r  = (mst == 1) ? 1'b0 : (mst == 2) ? 1'b1 : in_sel;
            er = r ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
            chk("in_ready", in_ready, er);
            chk("out0_valid", out0_valid, q0.size() != 0);
            chk("out1_valid", out1_valid, q1.size() != 0);
            if (out0_valid && out0_ready && q0.size() != 0) chk("out0_beat", {out0_last, out0_data}, q0.pop_front());
            if (out1_valid && out1_ready && q1.size() != 0) chk("out1_beat", {out1_last, out1_data}, q1.pop_front());
            if (in_valid && er) begin
                if (r) q1.push_back({in_last, in_data});
                else   q0.push_back({in_last, in_data});
                mst = in_last ? 2'd0 : (mst != 0) ? mst : (r ? 2'd2 : 2'd1);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rr0 = ($urandom_range(3) != 0);
        rr1 = ($urandom_range(3) != 0);
    end

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic s, input logic l);
        in_data = d; in_sel = s; in_last = l; in_valid = 1;
        wait_accept();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_state", dut.state, 0);
        // 1: single-beat packet to ch0
        send_beat(8'hA5, 0, 1);
        chk("t1_out0_valid", out0_valid, 1);
        chk("t1_out0_data", out0_data, 8'hA5);
        chk("t1_out0_last", out0_last, 1);
        chk("t1_out1_valid", out1_valid, 0);
        chk("t1_state", dut.state, 0);
        // 2: locked packet to ch1 while in_sel toggles
        send_beat(8'h11, 1, 0);
        chk("t2_state", dut.state, 2);
        send_beat(8'h22, 0, 0);
        send_beat(8'h33, 1, 0);
        send_beat(8'h44, 0, 1);
        chk("t2_out1_data", out1_data, 8'h44);
        chk("t2_out1_last", out1_last, 1);
        repeat (2) @(posedge clk);
        #1;
        // 3: backpressure on ch0
        dir0 = 0;
        send_beat(8'h01, 0, 0);
        in_data = 8'h02; in_last = 0; in_sel = 1; in_valid = 1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall_ready", in_ready, 0);
            chk("t3_hold_data", out0_data, 8'h01);
        end
        dir0 = 1;
        wait_accept();
        send_beat(8'h03, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        // 4: back-to-back packets to different channels
        send_beat(8'hAA, 0, 1);
        in_data = 8'hBB; in_sel = 1; in_last = 1; in_valid = 1;
        @(negedge clk);
        chk("t4_ready", in_ready, 1);
        wait_accept();
        chk("t4_out1_data", out1_data, 8'hBB);
        chk("t4_out0_valid", out0_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        // 5: async reset mid-packet
        dir1 = 0;
        send_beat(8'h77, 1, 0);
        chk("t5_state_lock1", dut.state, 2);
        #2 rst = 1;
        #1;
        chk("t5_out1_valid", out1_valid, 0);
        chk("t5_out1_data", out1_data, 0);
        chk("t5_state", dut.state, 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 0;
        dir1 = 1;
        @(posedge clk);
        #1;
        send_beat(8'h5A, 0, 1);
        chk("t5_out0_data", out0_data, 8'h5A);
        chk("t5_out1_after", out1_valid, 0);
        // 6: random traffic
        rand_rdy = 1;
        for (int i = 0; i < 10000; i++) begin
            int gap = $urandom_range(3) == 0 ? $urandom_range(2) : 0;
            repeat (gap) @(posedge clk);
            send_beat(8'($urandom), 1'($urandom), $urandom_range(3) == 0);
        end
        rand_rdy = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
